ddr2_init_seq: RTL and testbench

Parametrised DDR2 power-up initialisation sequencer; successor to the fixed-timing init block. Timing is derived from clock period and nanosecond parameters with ceiling rounding, and mode-register values are parameters. Adds a configurable auto-refresh count, a DLL-lock wait, an OCD default/exit step and a runtime re-initialisation request. It sits between reset and the command arbiter, which forwards `init_*` to the PHY until `init_end` rises.

---
 rtl/ddr2_pkg.sv | 29 ++
 rtl/ddr2_wait_timer.sv | 37 +++
 rtl/ddr2_init_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_ddr2_init_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_pkg.sv
// Shared DDR2 definitions: command encodings, mode-register bit positions
// and the ns-to-cycle conversion used by init and refresh logic.
package ddr2_pkg;

    typedef enum logic [3:0] {
        CMD_LM   = 4'b0000,
        CMD_AREF = 4'b0001,
        CMD_PRE  = 4'b0010,
        CMD_NOP  = 4'b0111
    } ddr2_cmd_e;

    localparam int A8_DLL_RST  = 8;
    localparam int OCD_LSB     = 7;
    localparam int OCD_MSB     = 9;
    localparam int A10_PRE_ALL = 10;

    // ceil(ns*1000/tck_ps), never below one cycle
    function automatic int cyc_ceil(input longint ns, input longint tck_ps);
        longint c;
        c = (ns * 64'd1000 + tck_ps - 64'd1) / tck_ps;
        if (c < 64'd1) c = 64'd1;
        return int'(c);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr2_wait_timer.sv
// Loadable down-counter that parks at zero; done is high while the count is zero.
module ddr2_wait_timer #(
    parameter int         W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (value_q != '0) begin
            value_d = value_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= RST_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign done  = (value_q == '0);

endmodule

// File: rtl/ddr2_init_seq.sv
// DDR2 power-up initialisation sequencer with parametrised timing and mode values.
// All outputs are registered; a runtime re-init restarts from the CKE-low wait.
module ddr2_init_seq
    import ddr2_pkg::*;
#(
    parameter int BA_BITS   = 3,
    parameter int ADDR_BITS = 13,
    parameter int TCK_PS    = 5000,
    parameter int T_INIT_NS = 300000,
    parameter int T_CKE_NS  = 400,
    parameter int TRP_NS    = 20,
    parameter int TRFC_NS   = 128,
    parameter int TMRD_CK   = 2,
    parameter int TDLL_CK   = 200,
    parameter int NUM_AREF  = 2,
    parameter logic [ADDR_BITS-1:0] MR_VAL   = ADDR_BITS'(13'h0432),
    parameter logic [ADDR_BITS-1:0] EMR1_VAL = ADDR_BITS'(13'h0010),
    parameter logic [ADDR_BITS-1:0] EMR2_VAL = '0,
    parameter logic [ADDR_BITS-1:0] EMR3_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 reinit_req,
    output logic                 init_cke,
    output logic [3:0]           init_cmd,
    output logic [BA_BITS-1:0]   init_ba,
    output logic [ADDR_BITS-1:0] init_addr,
    output logic                 init_busy,
    output logic                 init_end
);

    localparam int CYC_INIT = cyc_ceil(T_INIT_NS, TCK_PS);
    localparam int CYC_CKE  = cyc_ceil(T_CKE_NS, TCK_PS);
    localparam int CYC_RP   = cyc_ceil(TRP_NS, TCK_PS);
    localparam int CYC_RFC  = cyc_ceil(TRFC_NS, TCK_PS);
    localparam int MAX_GAP  = max_int(max_int(CYC_INIT, CYC_CKE),
                                      max_int(max_int(CYC_RP, CYC_RFC), TMRD_CK));
    localparam int TW       = $clog2(MAX_GAP + 1);
    localparam int DW       = (TDLL_CK < 1) ? 1 : $clog2(TDLL_CK + 1);

    // A gap of N cycles loads N-1: the next command issues on the edge that sees zero
    localparam logic [TW-1:0] LD_INIT = TW'(CYC_INIT - 1);
    localparam logic [TW-1:0] LD_CKE  = TW'(CYC_CKE - 1);
    localparam logic [TW-1:0] LD_RP   = TW'(CYC_RP - 1);
    localparam logic [TW-1:0] LD_RFC  = TW'(CYC_RFC - 1);
    localparam logic [TW-1:0] LD_MRD  = TW'(TMRD_CK - 1);
    localparam logic [TW-1:0] LD_DLLW = TW'(TMRD_CK);

    localparam logic [ADDR_BITS-1:0] A8_MASK   = ADDR_BITS'(1) << A8_DLL_RST;
    localparam logic [ADDR_BITS-1:0] OCD_MASK  = ADDR_BITS'(7) << OCD_LSB;
    localparam logic [ADDR_BITS-1:0] A10_MASK  = ADDR_BITS'(1) << A10_PRE_ALL;
    localparam logic [ADDR_BITS-1:0] EMR1_BASE = EMR1_VAL & ~OCD_MASK;
    localparam logic [DW-1:0]        DLL_MAX   = DW'(TDLL_CK);
    localparam logic [3:0]           AREF_MAX  = 4'(NUM_AREF);

    // Each command state holds the gap that follows its command
    typedef enum logic [3:0] {
        S_PWR, S_CKE, S_PRE1, S_EMR2, S_EMR3, S_EMR1, S_MR_DLLRST,
        S_PRE2, S_AREF, S_MR, S_EMR1_OCD, S_DLLW, S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic                   cke_q, cke_d;
    ddr2_cmd_e              cmd_q, cmd_d;
    logic [BA_BITS-1:0]     ba_q, ba_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   busy_q, busy_d;
    logic                   end_q, end_d;
    logic [3:0]             aref_q, aref_d;
    logic                   dll_run_q, dll_run_d;
    logic [DW-1:0]          dll_cnt_q, dll_cnt_d;

    logic                   tmr_load;
    logic [TW-1:0]          tmr_val;
    logic [TW-1:0]          tmr_value;
    logic                   tmr_done;

    ddr2_wait_timer #(
        .W       (TW),
        .RST_VAL (LD_INIT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_value),
        .done     (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        cke_d     = cke_q;
        cmd_d     = CMD_NOP;
        ba_d      = ba_q;
        addr_d    = addr_q;
        busy_d    = busy_q;
        end_d     = end_q;
        aref_d    = aref_q;
        dll_run_d = dll_run_q;
        dll_cnt_d = dll_cnt_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;

        if (dll_run_q && (dll_cnt_q != DLL_MAX)) begin
            dll_cnt_d = dll_cnt_q + 1'b1;
        end

        unique case (state_q)
            S_PWR: if (tmr_done) begin
                cke_d    = 1'b1;
                tmr_load = 1'b1;
                tmr_val  = LD_CKE;
                state_d  = S_CKE;
            end
            S_CKE: if (tmr_done) begin
                cmd_d    = CMD_PRE;
                ba_d     = '0;
                addr_d   = A10_MASK;
                tmr_load = 1'b1;
                tmr_val  = LD_RP;
                state_d  = S_PRE1;
            end
            S_PRE1: if (tmr_done) begin
                cmd_d    = CMD_LM;
                ba_d     = BA_BITS'(2);
                addr_d   = EMR2_VAL;
                tmr_load = 1'b1;
                tmr_val  = LD_MRD;
                state_d  = S_EMR2;
            end
            S_EMR2: if (tmr_done) begin
                cmd_d    = CMD_LM;
                ba_d     = BA_BITS'(3);
                addr_d   = EMR3_VAL;
                tmr_load = 1'b1;
                tmr_val  = LD_MRD;
                state_d  = S_EMR3;
            end
            S_EMR3: if (tmr_done) begin
                cmd_d    = CMD_LM;
                ba_d     = BA_BITS'(1);
                addr_d   = EMR1_BASE;
                tmr_load = 1'b1;
                tmr_val  = LD_MRD;
                state_d  = S_EMR1;
            end
            S_EMR1: if (tmr_done) begin
                cmd_d     = CMD_LM;
                ba_d      = '0;
                addr_d    = MR_VAL | A8_MASK;
                dll_run_d = 1'b1;
                dll_cnt_d = '0;
                tmr_load  = 1'b1;
                tmr_val   = LD_MRD;
                state_d   = S_MR_DLLRST;
            end
            S_MR_DLLRST: if (tmr_done) begin
                cmd_d    = CMD_PRE;
                ba_d     = '0;
                addr_d   = A10_MASK;
                tmr_load = 1'b1;
                tmr_val  = LD_RP;
                state_d  = S_PRE2;
            end
            S_PRE2: if (tmr_done) begin
                cmd_d    = CMD_AREF;
                aref_d   = 4'd1;
                tmr_load = 1'b1;
                tmr_val  = LD_RFC;
                state_d  = S_AREF;
            end
            S_AREF: if (tmr_done) begin
                tmr_load = 1'b1;
                if (aref_q == AREF_MAX) begin
                    cmd_d   = CMD_LM;
                    ba_d    = '0;
                    addr_d  = MR_VAL & ~A8_MASK;
                    tmr_val = LD_MRD;
                    state_d = S_MR;
                end else begin
                    cmd_d   = CMD_AREF;
                    aref_d  = aref_q + 4'd1;
                    tmr_val = LD_RFC;
                end
            end
            S_MR: if (tmr_done) begin
                cmd_d    = CMD_LM;
                ba_d     = BA_BITS'(1);
                addr_d   = EMR1_BASE | OCD_MASK;
                tmr_load = 1'b1;
                tmr_val  = LD_MRD;
                state_d  = S_EMR1_OCD;
            end
            S_EMR1_OCD: if (tmr_done) begin
                cmd_d    = CMD_LM;
                ba_d     = BA_BITS'(1);
                addr_d   = EMR1_BASE;
                tmr_load = 1'b1;
                tmr_val  = LD_DLLW;
                state_d  = S_DLLW;
            end
            // Leaves once tMRD after OCD exit has elapsed and the DLL has had its full lock time
            S_DLLW: if ((tmr_value == '0) && (dll_cnt_q == DLL_MAX)) begin
                busy_d  = 1'b0;
                end_d   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: if (reinit_req) begin
                cke_d     = 1'b0;
                ba_d      = '0;
                addr_d    = '0;
                busy_d    = 1'b1;
                end_d     = 1'b0;
                aref_d    = '0;
                dll_run_d = 1'b0;
                dll_cnt_d = '0;
                tmr_load  = 1'b1;
                tmr_val   = LD_INIT;
                state_d   = S_PWR;
            end
            default: state_d = S_PWR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_PWR;
            cke_q     <= 1'b0;
            cmd_q     <= CMD_NOP;
            ba_q      <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b1;
            end_q     <= 1'b0;
            aref_q    <= '0;
            dll_run_q <= 1'b0;
            dll_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cke_q     <= cke_d;
            cmd_q     <= cmd_d;
            ba_q      <= ba_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            end_q     <= end_d;
            aref_q    <= aref_d;
            dll_run_q <= dll_run_d;
            dll_cnt_q <= dll_cnt_d;
        end
    end

    assign init_cke  = cke_q;
    assign init_cmd  = cmd_q;
    assign init_ba   = ba_q;
    assign init_addr = addr_q;
    assign init_busy = busy_q;
    assign init_end  = end_q;

endmodule

// File: tb/tb_ddr2_init_seq.sv
// Bench for ddr2_init_seq: instance A (5 ns clock, short init) against a literal table,
// instance B (3.75 ns, 4 refreshes, long DLL wait) against a timeline model.
module tb_ddr2_init_seq;

    localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, AREF = 4'b0001, LM = 4'b0000;

    typedef struct packed {
        int          cyc;
        logic [3:0]  cmd;
        logic [2:0]  ba;
        logic [12:0] addr;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, reinit_a, reinit_b;
    logic        cke_a, busy_a, end_a, cke_b, busy_b, end_b;
    logic [3:0]  cmd_a, cmd_b;
    logic [2:0]  ba_a, ba_b;
    logic [12:0] addr_a, addr_b;

    ddr2_init_seq #(.T_INIT_NS(1000)) dut_a (
        .clk(clk), .rst_n(rst_n), .reinit_req(reinit_a), .init_cke(cke_a), .init_cmd(cmd_a),
        .init_ba(ba_a), .init_addr(addr_a), .init_busy(busy_a), .init_end(end_a));

    ddr2_init_seq #(.T_INIT_NS(1000), .TCK_PS(3750), .TRP_NS(15), .NUM_AREF(4), .TDLL_CK(2000)) dut_b (
        .clk(clk), .rst_n(rst_n), .reinit_req(reinit_b), .init_cke(cke_b), .init_cmd(cmd_b),
        .init_ba(ba_b), .init_addr(addr_b), .init_busy(busy_b), .init_end(end_b));

    int tests = 0;
    int fails = 0;

    ev_t tbl_a[12];
    ev_t exp_a[$], exp_b[$], cap_a[$], cap_b[$];
    int  exp_cke_b, exp_end_b;
    int  cke_at[2], end_at[2], bad[2];
    logic [2:0]  lba[2];
    logic [12:0] lad[2];

    task automatic chk(input string name, input bit ok, input string detail);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic int cyc(input longint ns, input longint tck);
        longint c;
        c = (ns * 1000 + tck - 1) / tck;
        return (c < 1) ? 1 : int'(c);
    endfunction

    task automatic add_ev(input int c, input logic [3:0] cm, input logic [2:0] b, input logic [12:0] a);
        ev_t e;
        e.cyc = c; e.cmd = cm; e.ba = b; e.addr = a;
        exp_b.push_back(e);
    endtask

    // Command timeline: each command lands exactly its predecessor's gap later
    task automatic build_model(input int tck, input int init_ns, input int cke_ns, input int rp_ns,
                               input int rfc_ns, input int mrd, input int dll, input int naref,
                               input logic [12:0] mr, input logic [12:0] emr1);
        int t, d, rp, rfc;
        logic [12:0] e1;
        e1  = emr1 & ~13'h380;
        rp  = cyc(rp_ns, tck);
        rfc = cyc(rfc_ns, tck);
        exp_b.delete();
        t = cyc(init_ns, tck);
        exp_cke_b = t;
        t += cyc(cke_ns, tck);
        add_ev(t, PRE, 3'd0, 13'h400);     t += rp;
        add_ev(t, LM, 3'd2, 13'h000);      t += mrd;
        add_ev(t, LM, 3'd3, 13'h000);      t += mrd;
        add_ev(t, LM, 3'd1, e1);           t += mrd;
        d = t;
        add_ev(t, LM, 3'd0, mr | 13'h100); t += mrd;
        add_ev(t, PRE, 3'd0, 13'h400);     t += rp;
        for (int i = 0; i < naref; i++) begin
            add_ev(t, AREF, 3'd0, 13'h400);
            t += rfc;
        end
        add_ev(t, LM, 3'd0, mr & ~13'h100); t += mrd;
        add_ev(t, LM, 3'd1, e1 | 13'h380);  t += mrd;
        add_ev(t, LM, 3'd1, e1);
        exp_end_b = (t + mrd + 1 > d + dll + 1) ? t + mrd + 1 : d + dll + 1;
    endtask

    task automatic samp(input int k, input int w, input logic cke, input logic [3:0] cm,
                        input logic [2:0] b, input logic [12:0] a, input logic busy, input logic fin);
        ev_t e;
        if (cm !== NOP) begin
            e.cyc = k; e.cmd = cm; e.ba = b; e.addr = a;
            if (w == 0) cap_a.push_back(e); else cap_b.push_back(e);
            if (cke_at[w] < 0) bad[w]++;
            lba[w] = b;
            lad[w] = a;
        end else if (b !== lba[w] || a !== lad[w]) begin
            bad[w]++;
        end
        if (cke === 1'b1 && cke_at[w] < 0) cke_at[w] = k;
        if (cke !== 1'b1 && cke_at[w] >= 0) bad[w]++;
        if (fin === 1'b1 && end_at[w] < 0) end_at[w] = k;
        if (busy !== ~fin) bad[w]++;
    endtask

    // Cycle 0 is the reset-release / re-init cycle; random re-init pulses land only while busy
    task automatic capture(input int stop_at);
        cap_a.delete(); cap_b.delete();
        for (int w = 0; w < 2; w++) begin
            cke_at[w] = -1; end_at[w] = -1; bad[w] = 0;
        end
        lba[0] = ba_a; lad[0] = addr_a; lba[1] = ba_b; lad[1] = addr_b;
        for (int k = 1; k <= 4000; k++) begin
            @(posedge clk); #1;
            samp(k, 0, cke_a, cmd_a, ba_a, addr_a, busy_a, end_a);
            samp(k, 1, cke_b, cmd_b, ba_b, addr_b, busy_b, end_b);
            reinit_a = (k < 300) && ($urandom_range(0, 9) == 0);
            reinit_b = (k < 300) && ($urandom_range(0, 9) == 0);
            if (k == stop_at) break;
            if (end_at[0] >= 0 && end_at[1] >= 0) break;
        end
        reinit_a = 1'b0;
        reinit_b = 1'b0;
        if (stop_at == 0)
            chk("seq_timeout", end_at[0] >= 0 && end_at[1] >= 0,
                $sformatf("init_end seen A=%0d B=%0d, required both within 4000 cycles", end_at[0], end_at[1]));
    endtask

    task automatic compare(input string tag, input int w, input ev_t exp[$], input int ecke, input int eend);
        ev_t got[$];
        if (w == 0) got = cap_a; else got = cap_b;
        chk({tag, "_ncmd"}, got.size() == exp.size(),
            $sformatf("got %0d commands, required %0d", got.size(), exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s_cmd%0d", tag, i), got[i] === exp[i],
                $sformatf("got cyc %0d cmd %b ba %0d addr %h, required cyc %0d cmd %b ba %0d addr %h",
                          got[i].cyc, got[i].cmd, got[i].ba, got[i].addr,
                          exp[i].cyc, exp[i].cmd, exp[i].ba, exp[i].addr));
        chk({tag, "_cke_rise"}, cke_at[w] == ecke, $sformatf("got cycle %0d, required %0d", cke_at[w], ecke));
        chk({tag, "_end_rise"}, end_at[w] == eend, $sformatf("got cycle %0d, required %0d", end_at[w], eend));
        chk({tag, "_levels"}, bad[w] == 0,
            $sformatf("%0d cycles with bad busy/cke/hold behaviour, required 0", bad[w]));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_a_cke"},  cke_a === 1'b0, $sformatf("got %b, required 0", cke_a));
        chk({tag, "_a_cmd"},  cmd_a === NOP, $sformatf("got %b, required 0111", cmd_a));
        chk({tag, "_a_ba"},   ba_a === 3'd0, $sformatf("got %0d, required 0", ba_a));
        chk({tag, "_a_addr"}, addr_a === 13'h0, $sformatf("got %h, required 0", addr_a));
        chk({tag, "_a_busy"}, busy_a === 1'b1, $sformatf("got %b, required 1", busy_a));
        chk({tag, "_a_end"},  end_a === 1'b0, $sformatf("got %b, required 0", end_a));
        chk({tag, "_b_all"}, {cke_b, cmd_b, ba_b, addr_b, busy_b, end_b} === {1'b0, NOP, 3'd0, 13'h0, 1'b1, 1'b0},
            $sformatf("got cke %b cmd %b ba %0d addr %h busy %b end %b, required reset values",
                      cke_b, cmd_b, ba_b, addr_b, busy_b, end_b));
    endtask

    task automatic plan_checks_b(input string tag);
        if (cap_b.size() >= 13) begin
            chk({tag, "_pre_gap"}, cap_b[1].cyc - cap_b[0].cyc == 4,
                $sformatf("got %0d, required 4", cap_b[1].cyc - cap_b[0].cyc));
            chk({tag, "_aref_gap"}, cap_b[7].cyc - cap_b[6].cyc == 35,
                $sformatf("got %0d, required 35", cap_b[7].cyc - cap_b[6].cyc));
            chk({tag, "_dll_end"}, end_at[1] - cap_b[4].cyc == 2001,
                $sformatf("got %0d, required 2001", end_at[1] - cap_b[4].cyc));
        end else begin
            chk({tag, "_short"}, 1'b0, $sformatf("got %0d commands, required 13", cap_b.size()));
        end
    endtask

    task automatic run_all(input string tag);
        compare({tag, "_a"}, 0, exp_a, 200, 491);
        compare({tag, "_b"}, 1, exp_b, exp_cke_b, exp_end_b);
        plan_checks_b(tag);
    endtask

    initial begin
        int stop;
        tbl_a[0]  = '{280, PRE,  3'd0, 13'h400};
        tbl_a[1]  = '{284, LM,   3'd2, 13'h000};
        tbl_a[2]  = '{286, LM,   3'd3, 13'h000};
        tbl_a[3]  = '{288, LM,   3'd1, 13'h010};
        tbl_a[4]  = '{290, LM,   3'd0, 13'h532};
        tbl_a[5]  = '{292, PRE,  3'd0, 13'h400};
        tbl_a[6]  = '{296, AREF, 3'd0, 13'h400};
        tbl_a[7]  = '{322, AREF, 3'd0, 13'h400};
        tbl_a[8]  = '{348, LM,   3'd0, 13'h432};
        tbl_a[9]  = '{350, LM,   3'd1, 13'h390};
        tbl_a[10] = '{352, LM,   3'd1, 13'h010};
        tbl_a[11] = '{491, NOP,  3'd0, 13'h000};
        for (int i = 0; i < 11; i++) exp_a.push_back(tbl_a[i]);
        chk("tbl_end_after_dllrst", tbl_a[11].cyc - tbl_a[4].cyc == 201,
            $sformatf("table end %0d vs MR_DLLRST %0d, required 201 apart", tbl_a[11].cyc, tbl_a[4].cyc));
        build_model(3750, 1000, 400, 15, 128, 2, 2000, 4, 13'h0432, 13'h0010);

        rst_n = 1'b0; reinit_a = 1'b0; reinit_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        @(negedge clk) rst_n = 1'b1;
        capture(0);
        run_all("run1");

        repeat ($urandom_range(0, 7)) begin
            @(posedge clk); #1;
        end
        reinit_a = 1'b1; reinit_b = 1'b1;
        @(posedge clk); #1;
        reinit_a = 1'b0; reinit_b = 1'b0;
        chk("reinit_a", {end_a, cke_a, busy_a} === 3'b001,
            $sformatf("got end %b cke %b busy %b, required 0 0 1", end_a, cke_a, busy_a));
        chk("reinit_b", {end_b, cke_b, busy_b} === 3'b001,
            $sformatf("got end %b cke %b busy %b, required 0 0 1", end_b, cke_b, busy_b));
        capture(0);
        run_all("run2");

        stop = $urandom_range(297, 347);
        capture(stop);
        rst_n = 1'b0;
        #1;
        chk_reset("mid_aref");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        capture(0);
        run_all("run3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
